// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle for mem_access_unit.
// The slave modport is the unit itself, and the master modport is whoever drives requests and models memory.
interface mem_access_unit_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       sb_empty;
  logic       MemRead;
  logic       MemWrite;
  logic [7:0] Address;
  logic [7:0] WriteData;
  logic [7:0] ReadData;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, ReadData,
    output req_ready, rsp_valid, rsp_data, rsp_err, sb_empty,
           MemRead, MemWrite, Address, WriteData
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, ReadData,
    input  req_ready, rsp_valid, rsp_data, rsp_err, sb_empty,
           MemRead, MemWrite, Address, WriteData
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end: an in-order store buffer with load forwarding, a single arbitrated
// memory port, and load/error responses that arrive a fixed two cycles after acceptance.
module mem_access_unit #(
  parameter int SB_DEPTH = 2,
  parameter int MEM_ROWS = 32
) (
  input logic            CLK,
  input logic            Reset,
  mem_access_unit_if.slave bus
);
  // state      | meaning
  // PORT_IDLE  | no memory access; Address/WriteData hold their last value
  // PORT_READ  | MemRead for the load accepted in the previous cycle
  // PORT_WRITE | MemWrite draining the store-buffer head
  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_READ  = 2'd1,
    PORT_WRITE = 2'd2
  } port_e;

  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  port_e            port_q, port_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;

  logic [7:0]       sb_addr_q [SB_DEPTH];
  logic [7:0]       sb_addr_d [SB_DEPTH];
  logic [7:0]       sb_data_q [SB_DEPTH];
  logic [7:0]       sb_data_d [SB_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_err_q, s1_err_d;
  logic             s1_mem_q, s1_mem_d;
  logic [7:0]       s1_data_q, s1_data_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       rsp_data_q, rsp_data_d;

  logic             sb_full;
  logic             accept;
  logic             in_range;
  logic             fwd_hit;
  logic [7:0]       fwd_data;
  logic             mem_load;
  logic             pop;
  logic             push;
  int               push_slot;

  assign sb_full       = (int'(cnt_q) == SB_DEPTH);
  assign bus.req_ready = !Reset && !sb_full;
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_range      = (int'(bus.req_addr) < MEM_ROWS);

  // Later entries are younger, so the last match in the scan wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (i < int'(cnt_q) && sb_addr_q[i] == bus.req_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[i];
      end
    end
  end

  assign mem_load  = accept && !bus.req_write && in_range && !fwd_hit;
  assign pop       = (cnt_q != '0) && !mem_load;
  assign push      = accept && bus.req_write && in_range;
  assign push_slot = pop ? int'(cnt_q) - 1 : int'(cnt_q);

  always_comb begin
    port_d  = PORT_IDLE;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (mem_load) begin
      port_d = PORT_READ;
      addr_d = bus.req_addr;
    end else if (pop) begin
      port_d  = PORT_WRITE;
      addr_d  = sb_addr_q[0];
      wdata_d = sb_data_q[0];
    end
  end

  // Head lives at index 0; a pop shifts everything down before the push lands.
  always_comb begin
    sb_addr_d = sb_addr_q;
    sb_data_d = sb_data_q;
    if (pop) begin
      for (int i = 0; i < SB_DEPTH - 1; i++) begin
        sb_addr_d[i] = sb_addr_q[i + 1];
        sb_data_d[i] = sb_data_q[i + 1];
      end
    end
    if (push) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (i == push_slot) begin
          sb_addr_d[i] = bus.req_addr;
          sb_data_d[i] = bus.req_wdata;
        end
      end
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    s1_valid_d = accept && (!in_range || !bus.req_write);
    s1_err_d   = accept && !in_range;
    s1_mem_d   = mem_load;
    s1_data_d  = (accept && !bus.req_write && in_range && fwd_hit) ? fwd_data : 8'h00;

    rsp_valid_d = s1_valid_q;
    rsp_err_d   = s1_valid_q && s1_err_q;
    rsp_data_d  = 8'h00;
    if (s1_valid_q && !s1_err_q) begin
      rsp_data_d = s1_mem_q ? bus.ReadData : s1_data_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      port_q      <= PORT_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sb_addr_q   <= '{default: '0};
      sb_data_q   <= '{default: '0};
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_mem_q    <= 1'b0;
      s1_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      port_q      <= port_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sb_addr_q   <= sb_addr_d;
      sb_data_q   <= sb_data_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_mem_q    <= s1_mem_d;
      s1_data_q   <= s1_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.MemRead   = (port_q == PORT_READ);
  assign bus.MemWrite  = (port_q == PORT_WRITE);
  assign bus.Address   = addr_q;
  assign bus.WriteData = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.sb_empty  = (cnt_q == '0);
endmodule
